// File: rtl/led_bank_arbiter.sv
// LED bank arbiter: round-robin sharing of the LED output buffers between
// requesters, with a minimum-ownership hold window before preemption and a
// free-running divided-counter pattern on the LEDs while nobody owns the bank.
module led_bank_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned DIV_BITS    = 26
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic                      owner_valid,
    output logic [$clog2(NREQ)-1:0]   owner_idx,
    output logic [WIDTH-1:0]          leds
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 owner_valid_q, owner_valid_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [DIV_BITS-1:0]  ctr_q, ctr_d;
    logic [WIDTH-1:0]     leds_q, leds_d;

    logic [WIDTH-1:0]     data_arr [NREQ];
    logic [NREQ-1:0]      cand_req;
    logic [IW:0]          pick_w;
    logic                 win_found;
    logic [IW-1:0]        win_idx;

    // Round-robin scan starting at p; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
        logic [IW:0] res;
        int unsigned c;
        res = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = 32'(p) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!res[IW] && r[IW'(c)]) res = {1'b1, IW'(c)};
        end
        return res;
    endfunction

    // Split the flat data bus into per-requester LED values.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
    end

    // Arbitration candidate set: the current owner never competes against itself.
    always_comb begin
        cand_req = req;
        if (state_q == OWN) cand_req[owner_q] = 1'b0;
        pick_w = rr_pick(cand_req, ptr_q);
    end

    assign win_found = pick_w[IW];
    assign win_idx   = pick_w[IW-1:0];

    // Next-state, grant, hold timer, idle counter and LED drive.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        leds_d        = leds_q;
        ctr_d         = ctr_q + DIV_BITS'(1);

        unique case (state_q)
            IDLE: begin
                leds_d = ctr_q[DIV_BITS-1 -: WIDTH];
                if (win_found) begin
                    state_d       = OWN;
                    gnt_d         = NREQ'(1) << win_idx;
                    owner_valid_d = 1'b1;
                    owner_d       = win_idx;
                    ptr_d         = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                    hold_d        = '0;
                end
            end
            OWN: begin
                leds_d = data_arr[owner_q];
                if (hold_q != HW'(HOLD_CYCLES)) hold_d = hold_q + HW'(1);
                // Release takes priority over expiry; preemption only once the window is full.
                if ((!req[owner_q] || (hold_q == HW'(HOLD_CYCLES))) && win_found) begin
                    gnt_d         = NREQ'(1) << win_idx;
                    owner_valid_d = 1'b1;
                    owner_d       = win_idx;
                    ptr_d         = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                    hold_d        = '0;
                end else if (!req[owner_q]) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    owner_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= '0;
            ptr_q         <= '0;
            hold_q        <= '0;
            ctr_q         <= '0;
            leds_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            ctr_q         <= ctr_d;
            leds_q        <= leds_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner_valid = owner_valid_q;
    assign owner_idx   = owner_q;
    assign leds        = leds_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random request traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_led_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned DIVB  = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [15:0] data  = '0;
    logic [3:0]  gnt;
    logic        owner_valid;
    logic [1:0]  owner_idx;
    logic [3:0]  leds;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: owner -1 means nobody owns the bank.
    int m_owner = -1;
    int m_oidx  = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_ctr   = 0;
    int m_leds  = 0;

    led_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .DIV_BITS(DIVB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt), .owner_valid(owner_valid), .owner_idx(owner_idx), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int excl);
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic grant(input int w);
        m_owner = w;
        m_oidx  = w;
        m_ptr   = (w + 1) % NREQ;
        m_hold  = 0;
    endtask

    task automatic model_update();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_oidx = 0; m_ptr = 0; m_hold = 0; m_ctr = 0; m_leds = 0;
            return;
        end
        if (m_owner < 0) begin
            m_leds = m_ctr / (1 << (DIVB - WIDTH));
            w = pick(req, -1);
            if (w >= 0) grant(w);
        end else begin
            m_leds = (int'(data) >> (m_owner * WIDTH)) % 16;
            w = pick(req, m_owner);
            if (!req[m_owner]) begin
                if (w >= 0) grant(w);
                else m_owner = -1;
            end else if (m_hold == HOLD && w >= 0) begin
                grant(w);
            end else if (m_hold < HOLD) begin
                m_hold++;
            end
        end
        m_ctr = (m_ctr + 1) % (1 << DIVB);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("gnt", 32'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("owner_valid", 32'(owner_valid), (m_owner >= 0) ? 1 : 0);
        check("owner_idx", 32'(owner_idx), m_oidx);
        check("leds", 32'(leds), m_leds);
        check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
        check("gnt_vs_valid", 32'((gnt == 4'b0) == !owner_valid), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;

        // Reset then idle counter pattern.
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 1) begin
                check("first_gnt", 32'(gnt), 0);
                check("first_leds", 32'(leds), 0);
            end
            check("idle_leds", 32'(leds), ((k - 1) % 64) >> 2);
        end

        // Single request.
        data = 16'h00A0;
        req  = 4'b0010;
        step();
        check("single_gnt", 32'(gnt), 32'h2);
        step();
        check("single_leds", 32'(leds), 32'hA);
        step();
        req = 4'b0000;
        step();
        check("single_release", 32'(gnt), 0);
        step();
        step();

        // Simultaneous requests, back-to-back handoff, re-raise.
        do_reset();
        data = 16'h5A3C;
        req  = 4'b0101;
        step();
        check("simul_first", 32'(gnt), 32'h1);
        step();
        req = 4'b0100;
        step();
        check("handoff_gnt", 32'(gnt), 32'h4);
        check("handoff_valid", 32'(owner_valid), 1);
        req = 4'b0101;
        step();
        step();
        req = 4'b0001;
        step();
        check("reraise_gnt", 32'(gnt), 32'h1);
        step();

        // Preemption after the hold window.
        do_reset();
        req = 4'b0001;
        step();
        cnt = 0;
        step(); cnt++;
        step(); cnt++;
        req = 4'b1001;
        while (gnt != 4'b1000 && cnt < 20) begin
            step(); cnt++;
        end
        check("preempt_edges", 32'(cnt), HOLD + 1);
        cnt = 0;
        while (gnt != 4'b0001 && cnt < 20) begin
            step(); cnt++;
        end
        check("regain_edges", 32'(cnt), HOLD + 1);

        // Only requester past expiry, then another arrives.
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 21; k++) step();
        check("alone_gnt", 32'(gnt), 32'h2);
        req = 4'b0110;
        step();
        check("late_preempt", 32'(gnt), 32'h4);

        // Reset in mid-ownership.
        do_reset();
        data = 16'h7000;
        req  = 4'b1000;
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b0;
        step();
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_leds", 32'(leds), 0);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        check("midrst_first", 32'(gnt), 32'h1);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
            data  = 16'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
